// File: rtl/pipeline_ctrl.sv
// Hazard controller for a 5-stage pipeline: operand forwarding, load-use and
// redirect handling, data-memory wait stalls with timeout, and saturating perf counters.
module pipeline_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       Rs1_E,
  input  logic [4:0]       Rs2_E,
  input  logic [4:0]       Rd_E,
  input  logic [1:0]       ResultSrc_E,
  input  logic             PCSrc_E,
  input  logic [4:0]       Rd_M,
  input  logic [4:0]       Rd_W,
  input  logic             RegWrite_M,
  input  logic             RegWrite_W,
  input  logic             mem_req_M,
  input  logic             mem_ready,
  output logic             Stall_F,
  output logic             Stall_D,
  output logic             Stall_E,
  output logic             Stall_M,
  output logic             Flush_D,
  output logic             Flush_E,
  output logic             Flush_W,
  output logic [1:0]       ForwardA_E,
  output logic [1:0]       ForwardB_E,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // state    | meaning
  // RUN      | normal flow; load-use / redirect / memory-stall detection
  // MEM_WAIT | data access outstanding, whole pipe held, wait counter running
  // ERR      | memory timed out; pipe frozen until reset

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic w_load_use;
  logic w_mem_stall;
  logic w_stall_f, w_stall_d, w_stall_e, w_stall_m;
  logic w_flush_d, w_flush_e, w_flush_w;

  always_comb begin
    ForwardA_E = 2'b00;
    if (RegWrite_M && (Rd_M != 5'd0) && (Rd_M == Rs1_E))
      ForwardA_E = 2'b10;
    else if (RegWrite_W && (Rd_W != 5'd0) && (Rd_W == Rs1_E))
      ForwardA_E = 2'b01;

    ForwardB_E = 2'b00;
    if (RegWrite_M && (Rd_M != 5'd0) && (Rd_M == Rs2_E))
      ForwardB_E = 2'b10;
    else if (RegWrite_W && (Rd_W != 5'd0) && (Rd_W == Rs2_E))
      ForwardB_E = 2'b01;
  end

  assign w_load_use = (ResultSrc_E == 2'b01) && (Rd_E != 5'd0) &&
                      ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));

  // In MEM_WAIT the access is already outstanding, so only mem_ready matters.
  assign w_mem_stall = ((r_state == RUN) && mem_req_M && !mem_ready) ||
                       ((r_state == MEM_WAIT) && !mem_ready);

  always_comb begin
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_stall_e = 1'b0;
    w_stall_m = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    w_flush_w = 1'b0;
    if ((r_state == ERR) || w_mem_stall) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_stall_e = 1'b1;
      w_stall_m = 1'b1;
      w_flush_w = 1'b1;
    end else if (PCSrc_E) begin
      w_flush_d = 1'b1;
      w_flush_e = 1'b1;
    end else if (w_load_use) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_flush_e = 1'b1;
    end
  end

  // Control outputs are forced low for the whole reset window, not just after the edge.
  assign Stall_F = w_stall_f & rst;
  assign Stall_D = w_stall_d & rst;
  assign Stall_E = w_stall_e & rst;
  assign Stall_M = w_stall_m & rst;
  assign Flush_D = w_flush_d & rst;
  assign Flush_E = w_flush_e & rst;
  assign Flush_W = w_flush_w & rst;

  assign mem_err   = (r_state == ERR);
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_mem_stall) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt >= WAIT_MAX) begin
            r_state <= ERR;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        ERR:     r_state <= ERR;
        default: r_state <= RUN;
      endcase

      if (w_stall_f && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if ((w_flush_d || w_flush_e) && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl: hazards, forwarding, memory
// wait/timeout, reset recovery and counter saturation (second narrow-counter instance).
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst, rst4;
  logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
  logic [1:0] ResultSrc_E;
  logic PCSrc_E, RegWrite_M, RegWrite_W, mem_req_M, mem_ready;

  logic Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W, mem_err;
  logic [1:0] ForwardA_E, ForwardB_E;
  logic [31:0] stall_cnt, flush_cnt;

  logic Stall_F_4, Stall_D_4, Stall_E_4, Stall_M_4, Flush_D_4, Flush_E_4, Flush_W_4, mem_err_4;
  logic [1:0] ForwardA_E_4, ForwardB_E_4;
  logic [3:0] stall_cnt_4, flush_cnt_4;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .Rd_E(Rd_E), .ResultSrc_E(ResultSrc_E), .PCSrc_E(PCSrc_E), .Rd_M(Rd_M), .Rd_W(Rd_W),
    .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W), .mem_req_M(mem_req_M),
    .mem_ready(mem_ready), .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E),
    .Stall_M(Stall_M), .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_W(Flush_W),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_ctrl #(.TIMEOUT(255), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst4), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .Rd_E(Rd_E), .ResultSrc_E(ResultSrc_E), .PCSrc_E(PCSrc_E), .Rd_M(Rd_M), .Rd_W(Rd_W),
    .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W), .mem_req_M(mem_req_M),
    .mem_ready(mem_ready), .Stall_F(Stall_F_4), .Stall_D(Stall_D_4), .Stall_E(Stall_E_4),
    .Stall_M(Stall_M_4), .Flush_D(Flush_D_4), .Flush_E(Flush_E_4), .Flush_W(Flush_W_4),
    .ForwardA_E(ForwardA_E_4), .ForwardB_E(ForwardB_E_4), .mem_err(mem_err_4),
    .stall_cnt(stall_cnt_4), .flush_cnt(flush_cnt_4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // s = {Stall_F,Stall_D,Stall_E,Stall_M}, f = {Flush_D,Flush_E,Flush_W}
  task automatic chk_ctl(input string tag, input logic [3:0] s, input logic [2:0] f);
    chk({tag, "_stall"}, {28'd0, Stall_F, Stall_D, Stall_E, Stall_M}, {28'd0, s});
    chk({tag, "_flush"}, {29'd0, Flush_D, Flush_E, Flush_W}, {29'd0, f});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0; Rd_E = 0; Rd_M = 0; Rd_W = 0;
    ResultSrc_E = 2'b00; PCSrc_E = 0; RegWrite_M = 0; RegWrite_W = 0;
    mem_req_M = 0; mem_ready = 0;
  endtask

  task automatic set_load_use();
    ResultSrc_E = 2'b01; Rd_E = 5'd7; Rs1_D = 5'd7;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst = 0; rst4 = 0;
    idle();
    set_load_use();
    PCSrc_E = 1; mem_req_M = 1;
    #2;
    chk_ctl("in_reset", 4'b0000, 3'b000);
    chk("in_reset_mem_err", {31'd0, mem_err}, 32'd0);
    chk("in_reset_stall_cnt", stall_cnt, 32'd0);
    chk("in_reset_flush_cnt", flush_cnt, 32'd0);

    idle();
    @(negedge clk);
    rst = 1;
    tick();
    chk_ctl("idle", 4'b0000, 3'b000);

    set_load_use();
    #1 chk_ctl("load_use", 4'b1100, 3'b010);
    tick();
    idle();
    #1;
    chk("load_use_stall_cnt", stall_cnt, 32'd1);
    chk("load_use_flush_cnt", flush_cnt, 32'd1);

    ResultSrc_E = 2'b01; Rd_E = 5'd0; Rs1_D = 5'd0;
    #1 chk_ctl("load_x0", 4'b0000, 3'b000);
    ResultSrc_E = 2'b00; Rd_E = 5'd7; Rs2_D = 5'd7;
    #1 chk_ctl("alu_match", 4'b0000, 3'b000);

    idle();
    ResultSrc_E = 2'b01; Rd_E = 5'd7; Rs2_D = 5'd7; PCSrc_E = 1;
    #1 chk_ctl("redirect_over_lu", 4'b0000, 3'b110);
    tick();
    idle();
    #1;
    chk("redirect_stall_cnt", stall_cnt, 32'd1);
    chk("redirect_flush_cnt", flush_cnt, 32'd2);

    Rd_M = 5; Rd_W = 5; RegWrite_M = 1; RegWrite_W = 1; Rs1_E = 5; Rs2_E = 0;
    #1;
    chk("fwd_a_mem_prio", {30'd0, ForwardA_E}, 32'd2);
    chk("fwd_b_x0", {30'd0, ForwardB_E}, 32'd0);
    Rs1_E = 3; Rs2_E = 9; Rd_M = 9; Rd_W = 3;
    #1;
    chk("fwd_a_wb", {30'd0, ForwardA_E}, 32'd1);
    chk("fwd_b_mem", {30'd0, ForwardB_E}, 32'd2);
    RegWrite_M = 0; Rs1_E = 9; Rd_W = 9;
    #1;
    chk("fwd_b_wb_nowrm", {30'd0, ForwardB_E}, 32'd1);
    Rd_M = 0; Rd_W = 0; RegWrite_M = 1; Rs1_E = 0; Rs2_E = 0;
    #1;
    chk("fwd_a_rd0", {30'd0, ForwardA_E}, 32'd0);

    idle();
    mem_ready = 1;
    #1 chk_ctl("ready_no_req", 4'b0000, 3'b000);
    tick();
    chk("ready_no_req_cnt", stall_cnt, 32'd1);

    idle();
    mem_req_M = 1; PCSrc_E = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk_ctl("mem_wait", 4'b1111, 3'b001);
      tick();
    end
    mem_ready = 1;
    #1 chk_ctl("mem_release", 4'b0000, 3'b110);
    tick();
    idle();
    #1;
    chk("mem_stall_cnt", stall_cnt, 32'd4);
    chk("mem_flush_cnt", flush_cnt, 32'd3);
    chk("mem_no_err", {31'd0, mem_err}, 32'd0);

    mem_req_M = 1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("pre_timeout_err", {31'd0, mem_err}, 32'd0);
      tick();
    end
    #1 chk("timeout_err", {31'd0, mem_err}, 32'd1);
    mem_ready = 1; PCSrc_E = 1;
    #1 chk_ctl("err_ctl", 4'b1111, 3'b001);
    tick();
    chk("err_sticky", {31'd0, mem_err}, 32'd1);
    chk("err_stall_cnt", stall_cnt, 32'd10);
    chk("err_flush_cnt", flush_cnt, 32'd3);

    rst = 0;
    #1;
    chk("rst_err_clear", {31'd0, mem_err}, 32'd0);
    chk("rst_stall_clear", stall_cnt, 32'd0);
    chk_ctl("rst_ctl", 4'b0000, 3'b000);
    mem_ready = 0; PCSrc_E = 0;
    @(negedge clk);
    rst = 1;
    tick();
    tick();
    rst = 0;
    #1 chk("rst_mid_wait_cnt", stall_cnt, 32'd0);
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("post_rst_no_err", {31'd0, mem_err}, 32'd0);
      tick();
    end
    #1;
    chk("post_rst_timeout", {31'd0, mem_err}, 32'd1);
    chk("post_rst_stall_cnt", stall_cnt, 32'd5);

    idle();
    set_load_use();
    @(negedge clk);
    rst4 = 1;
    for (int i = 0; i < 14; i++) tick();
    chk("sat_pre", {28'd0, stall_cnt_4}, 32'd14);
    for (int i = 0; i < 6; i++) tick();
    chk("sat_stall", {28'd0, stall_cnt_4}, 32'hF);
    chk("sat_flush", {28'd0, flush_cnt_4}, 32'hF);
    chk("sat_still_stalling", {31'd0, Stall_F_4}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, max consecutive MEM_WAIT cycles before error.
REQ-002 Parameter CNT_W, default 32, width of performance counters.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 Rs1_D, Rs2_D  input  5 each  source registers of decode instruction.
REQ-006 Rs1_E, Rs2_E, Rd_E  input  5 each  source/dest registers in execute.
REQ-007 ResultSrc_E  input  2  execute result select; 2'b01 = load.
REQ-008 PCSrc_E  input  1  taken branch/jump redirect from execute.
REQ-009 Rd_M, Rd_W  input  5 each; RegWrite_M, RegWrite_W  input  1 each.
REQ-010 mem_req_M  input  1  memory-stage data access in progress; mem_ready  input  1  data memory completes access this cycle.
REQ-011 Stall_F, Stall_D, Stall_E, Stall_M  output  1 each  hold stage register.
REQ-012 Flush_D, Flush_E, Flush_W  output  1 each  clear stage register to bubble.
REQ-013 ForwardA_E, ForwardB_E  output  2 each  00 regfile, 01 writeback, 10 memory.
REQ-014 mem_err  output  1  sticky memory-timeout error.
REQ-015 stall_cnt, flush_cnt  output  CNT_W each  performance counters.

Function
REQ-016 FSM states RUN, MEM_WAIT, ERR; stall/flush/forward outputs SHALL be combinational from state and inputs, counters and state registered.
REQ-017 ForwardA_E SHALL be 10 if RegWrite_M and Rd_M!=0 and Rd_M==Rs1_E, else 01 if RegWrite_W and Rd_W!=0 and Rd_W==Rs1_E, else 00; ForwardB_E identical using Rs2_E; memory stage has priority.
REQ-018 load_use SHALL be ResultSrc_E==01 and Rd_E!=0 and (Rd_E==Rs1_D or Rd_E==Rs2_D).
REQ-019 RUN, mem_req_M=1 and mem_ready=0: assert Stall_F/D/E/M and Flush_W; next state MEM_WAIT; wait counter loads 1.
REQ-020 RUN, no memory stall, PCSrc_E=1: assert Flush_D and Flush_E, Stall_F=0, regardless of load_use.
REQ-021 RUN, no memory stall, PCSrc_E=0, load_use=1: assert Stall_F, Stall_D, Flush_E.
REQ-022 Memory stall SHALL take priority over redirect and load-use; those are suppressed while memory stall is active and re-evaluated when it releases.
REQ-023 MEM_WAIT, mem_ready=0: same outputs as REQ-019; wait counter increments; counter reaching TIMEOUT SHALL move to ERR next edge.
REQ-024 MEM_WAIT, mem_ready=1: no memory stall this cycle (REQ-020/021 apply); next state RUN; wait counter cleared.
REQ-025 ERR: Stall_F/D/E/M=1, Flush_W=1, mem_err=1, all other flushes 0; exit only by reset.
REQ-026 stall_cnt SHALL increment on every cycle with Stall_F=1; flush_cnt on every cycle with Flush_D or Flush_E=1; both saturate at all-ones, no wrap.
REQ-027 mem_ready=1 with mem_req_M=0 SHALL be ignored.

Reset
REQ-028 While rst=0: state RUN, wait counter 0, mem_err 0, stall_cnt 0, flush_cnt 0, all stall/flush outputs 0, asserted asynchronously.
REQ-029 Reset mid-MEM_WAIT or in ERR SHALL return to RUN with counters cleared; first post-reset edge behaves as REQ-019..021.

Verification
REQ-030 Rd_E=7, ResultSrc_E=01, Rs1_D=7 -> Stall_F=1, Stall_D=1, Flush_E=1 one cycle; stall_cnt=1.
REQ-031 Load-use plus PCSrc_E=1 same cycle -> Flush_D=1, Flush_E=1, Stall_F=0; flush_cnt=1, stall_cnt=0.
REQ-032 Rd_M=Rd_W=5, both RegWrite, Rs1_E=5, Rs2_E=0 -> ForwardA_E=10, ForwardB_E=00.
REQ-033 mem_req_M=1, mem_ready low 3 cycles then high -> stalls+Flush_W for 3 cycles, released in 4th, state RUN, stall_cnt=3.
REQ-034 TIMEOUT=4, mem_ready held 0 -> ERR entered after 4 wait cycles, mem_err=1 sticky; rst=0 clears it.
REQ-035 Force stall_cnt near all-ones (CNT_W=4), 20 stall cycles -> stall_cnt holds 4'hF.
